// File: rtl/osc_meas_pkg.sv
// osc_meas_pkg: shared state enum, default phase lengths and channel-width helper for osc_meas_sched
package osc_meas_pkg;
  typedef enum logic [2:0] {IDLE, CLEAR, RUN, STOP, CAPTURE, RESULT} state_t;
  localparam int DEF_CLEAR_CYCLES = 8;
  localparam int DEF_SETTLE_CYCLES = 4;
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/osc_meas_phase_timer.sv
// osc_meas_phase_timer: loadable down-counter whose done flag marks the last cycle of an N-cycle phase
module osc_meas_phase_timer #(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk)
    if (rst) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (cnt != '0) cnt <= cnt - 1'b1;
  assign done = cnt == W'(1);
endmodule

// File: rtl/osc_meas_sched.sv
// osc_meas_sched: ring-oscillator measurement scheduler; REQ_CH carries one spare bit so out-of-range channels can be rejected; RES_STUCK exists only with OSC_MEAS_SCHED_STUCK_DETECT_EN
module osc_meas_sched
  import osc_meas_pkg::*;
#(
  parameter int NUM_OSC = 4,
  parameter int COUNTER_LENGTH = 128,
  parameter int WIN_W = 16,
  parameter int CLEAR_CYCLES = DEF_CLEAR_CYCLES,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
  input  logic                              CLK,
  input  logic                              RESET,
  input  logic                              REQ_VALID,
  output logic                              REQ_READY,
  input  logic [ch_w(NUM_OSC):0]            REQ_CH,
  input  logic [WIN_W-1:0]                  REQ_WINDOW,
  output logic [NUM_OSC-1:0]                OSC_EN,
  output logic [NUM_OSC-1:0]                OSC_RESET,
  input  logic [NUM_OSC*COUNTER_LENGTH-1:0] OSC_COUNT,
  output logic                              RES_VALID,
  input  logic                              RES_READY,
  output logic [ch_w(NUM_OSC)-1:0]          RES_CH,
  output logic [COUNTER_LENGTH-1:0]         RES_COUNT,
  output logic                              RES_ERR,
  output logic                              BUSY
`ifdef OSC_MEAS_SCHED_STUCK_DETECT_EN
  , output logic                            RES_STUCK
`endif
);
  localparam int CW = ch_w(NUM_OSC);
  localparam int CLR_W = $clog2(CLEAR_CYCLES + 1);
  localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
  localparam int MAX_W = (WIN_W > CLR_W) ? WIN_W : CLR_W;
  localparam int PH_W = ((MAX_W > SET_W) ? MAX_W : SET_W) + 1;
  localparam logic [CW:0] NUM_CH = NUM_OSC[CW:0];
  state_t state, next_state;
  logic [CW-1:0] ch;
  logic [WIN_W-1:0] win;
  logic ld, done, accept, ch_ok;
  logic [PH_W-1:0] ld_val;
  logic [NUM_OSC-1:0] oh;
  logic [COUNTER_LENGTH-1:0] cnt_arr [NUM_OSC];
  logic [COUNTER_LENGTH-1:0] sel;
  for (genvar i = 0; i < NUM_OSC; i++) begin : g_slice
    assign cnt_arr[i] = OSC_COUNT[i*COUNTER_LENGTH +: COUNTER_LENGTH];
  end
  assign sel = cnt_arr[ch];
  assign ch_ok = REQ_CH < NUM_CH;
  assign accept = REQ_VALID && state == IDLE;
  assign oh = NUM_OSC'(1) << ch;
  assign OSC_EN = (state == CLEAR || state == RUN) ? oh : '0;
  assign OSC_RESET = (state == RUN || state == STOP || state == CAPTURE) ? ~oh : '1;
  assign REQ_READY = state == IDLE;
  assign RES_VALID = state == RESULT;
  assign BUSY = state != IDLE;
  osc_meas_phase_timer #(.W(PH_W)) u_timer (
    .clk(CLK),
    .rst(RESET),
    .load(ld),
    .load_val(ld_val),
    .done(done)
  );
  always_comb begin
    next_state = state;
    ld = 1'b0;
    ld_val = '0;
    case (state)
      IDLE: begin
        next_state = REQ_VALID ? (ch_ok ? CLEAR : RESULT) : IDLE;
        ld = REQ_VALID && ch_ok;
        ld_val = PH_W'(CLEAR_CYCLES);
      end
      CLEAR: begin
        next_state = done ? RUN : CLEAR;
        ld = done;
        ld_val = PH_W'(win);
      end
      RUN: begin
        next_state = done ? STOP : RUN;
        ld = done;
        ld_val = PH_W'(SETTLE_CYCLES);
      end
      STOP: next_state = done ? CAPTURE : STOP;
      CAPTURE: next_state = RESULT;
      RESULT: next_state = RES_READY ? IDLE : RESULT;
      default: next_state = IDLE;
    endcase
  end
  always_ff @(posedge CLK)
    if (RESET) begin
      state <= IDLE;
      ch <= '0;
      win <= '0;
      RES_CH <= '0;
      RES_COUNT <= '0;
      RES_ERR <= 1'b0;
`ifdef OSC_MEAS_SCHED_STUCK_DETECT_EN
      RES_STUCK <= 1'b0;
`endif
    end else begin
      state <= next_state;
      if (accept) begin
        ch <= REQ_CH[CW-1:0];
        win <= (REQ_WINDOW == '0) ? WIN_W'(1) : REQ_WINDOW;
        RES_CH <= '0;
        RES_COUNT <= '0;
        RES_ERR <= !ch_ok;
`ifdef OSC_MEAS_SCHED_STUCK_DETECT_EN
        RES_STUCK <= 1'b0;
`endif
      end
      if (state == CAPTURE) begin
        RES_CH <= ch;
        RES_COUNT <= sel;
        RES_ERR <= 1'b0;
`ifdef OSC_MEAS_SCHED_STUCK_DETECT_EN
        RES_STUCK <= sel == '0;
`endif
      end
    end
endmodule
